// File: rtl/mem_lsu_ctrl.sv
// Load/store unit controller: accepts one byte/half/word request at a time, does a
// read-modify-write for partial stores and returns an aligned, extended load result.
module mem_lsu_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pLsu_bReqValid,
   output logic                  pLsu_bReqReady,
   input  logic                  pLsu_bReqWr,
   input  logic [1:0]            pLsu_bReqSize,
   input  logic                  pLsu_bReqSigned,
   input  logic [ADDR_WIDTH-1:0] pLsu_bReqAddr,
   input  logic [DATA_WIDTH-1:0] pLsu_bReqData,
   output logic                  pLsu_bRespValid,
   input  logic                  pLsu_bRespReady,
   output logic [DATA_WIDTH-1:0] pLsu_bRespData,
   output logic                  pLsu_bRespErr,
   output logic                  pMem_bRdEn,
   output logic [ADDR_WIDTH-1:0] pMem_bRdAddrB,
   input  logic [DATA_WIDTH-1:0] pMem_bRdDataB,
   output logic                  pMem_bWrEn,
   output logic [ADDR_WIDTH-1:0] pMem_bWrAddr,
   output logic [DATA_WIDTH-1:0] pMem_bWrData,
   output logic                  pMem_bWrMask_0,
   output logic                  pMem_bWrMask_1,
   output logic                  pMem_bWrMask_2,
   output logic                  pMem_bWrMask_3
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } state_t;

   state_t                state_q, state_d;
   logic                  wr_q, wr_d;
   logic [1:0]            size_q, size_d;
   logic                  signed_q, signed_d;
   logic [1:0]            off_q, off_d;
   logic [15:0]           data_q, data_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [3:0]            mask_q, mask_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                  resp_err_q, resp_err_d;
   logic [15:0]           st_s;
   logic [ADDR_WIDTH-1:0] req_aligned_s;

   function automatic logic is_err(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'b00:   is_err = 1'b0;
         2'b01:   is_err = a[0];
         2'b10:   is_err = (a != 2'b00);
         default: is_err = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'b00:   lane_mask = 4'b0001 << a;
         2'b01:   lane_mask = a[1] ? 4'b1100 : 4'b0011;
         2'b10:   lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   endfunction

   // Store data arrives pre-replicated per half-lane, so odd lanes take the high byte.
   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] w,
                                                   input logic [15:0] st, input logic [3:0] m);
      merge = w;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            merge[8*i +: 8] = i[0] ? st[15:8] : st[7:0];
         end else begin
            merge[8*i +: 8] = w[8*i +: 8];
         end
      end
   endfunction

   function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [1:0] sz, input logic sg,
                                                     input logic [1:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = w[{a[1], 4'b0000} +: 16];
      case (sz)
         2'b00:   extract = {{(DATA_WIDTH-8){sg & b[7]}}, b};
         2'b01:   extract = {{(DATA_WIDTH-16){sg & h[15]}}, h};
         2'b10:   extract = w;
         default: extract = {DATA_WIDTH{1'b0}};
      endcase
   endfunction

   assign req_aligned_s = {pLsu_bReqAddr[ADDR_WIDTH-1:2], 2'b00};

   // Next-state and register updates for the request/response sequencer.
   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      size_d      = size_q;
      signed_d    = signed_q;
      off_d       = off_q;
      data_d      = data_q;
      rd_addr_d   = rd_addr_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      mask_d      = 4'b0000;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      st_s        = (size_q == 2'b00) ? {data_q[7:0], data_q[7:0]} : data_q;
      case (state_q)
         ST_IDLE: begin
            if (pLsu_bReqValid) begin
               wr_d        = pLsu_bReqWr;
               size_d      = pLsu_bReqSize;
               signed_d    = pLsu_bReqSigned;
               off_d       = pLsu_bReqAddr[1:0];
               data_d      = pLsu_bReqData[15:0];
               rd_addr_d   = req_aligned_s;
               wr_addr_d   = req_aligned_s;
               resp_data_d = {DATA_WIDTH{1'b0}};
               resp_err_d  = is_err(pLsu_bReqSize, pLsu_bReqAddr[1:0]);
               if (is_err(pLsu_bReqSize, pLsu_bReqAddr[1:0])) begin
                  state_d = ST_RESP;
               end else if (pLsu_bReqWr && (pLsu_bReqSize == 2'b10)) begin
                  state_d   = ST_WR;
                  wr_data_d = pLsu_bReqData;
                  mask_d    = 4'b1111;
               end else begin
                  state_d = ST_RD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            if (wr_q) begin
               state_d   = ST_WR;
               mask_d    = lane_mask(size_q, off_q);
               wr_data_d = merge(pMem_bRdDataB, st_s, lane_mask(size_q, off_q));
            end else begin
               state_d     = ST_RESP;
               resp_data_d = extract(pMem_bRdDataB, size_q, signed_q, off_q);
            end
         end
         ST_WR: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (pLsu_bRespReady) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wr_q        <= 1'b0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         off_q       <= 2'b00;
         data_q      <= 16'h0000;
         rd_addr_q   <= {ADDR_WIDTH{1'b0}};
         wr_addr_q   <= {ADDR_WIDTH{1'b0}};
         wr_data_q   <= {DATA_WIDTH{1'b0}};
         mask_q      <= 4'b0000;
         resp_data_q <= {DATA_WIDTH{1'b0}};
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         off_q       <= off_d;
         data_q      <= data_d;
         rd_addr_q   <= rd_addr_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         mask_q      <= mask_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   assign pLsu_bReqReady  = (state_q == ST_IDLE);
   assign pLsu_bRespValid = (state_q == ST_RESP);
   assign pMem_bRdEn      = (state_q == ST_RD);
   assign pMem_bWrEn      = (state_q == ST_WR);
   assign pLsu_bRespData  = resp_data_q;
   assign pLsu_bRespErr   = resp_err_q;
   assign pMem_bRdAddrB   = rd_addr_q;
   assign pMem_bWrAddr    = wr_addr_q;
   assign pMem_bWrData    = wr_data_q;
   assign pMem_bWrMask_0  = mask_q[0];
   assign pMem_bWrMask_1  = mask_q[1];
   assign pMem_bWrMask_2  = mask_q[2];
   assign pMem_bWrMask_3  = mask_q[3];

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed bench for mem_lsu_ctrl with a word-addressed memory model and
// hand-computed expected results.
module tb_mem_lsu_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_wr, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_data;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_data;
   logic        rd_en, wr_en;
   logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
   logic        m0, m1, m2, m3;

   logic [31:0] mem [0:1023];

   int          vec_cnt  = 0;
   int          miss_cnt = 0;
   int          lat;
   logic        seen_rd, seen_wr;
   logic [31:0] obs_rd_addr, obs_wr_addr, obs_wr_data;
   logic [3:0]  obs_mask;

   mem_lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clock(clock), .reset(reset),
      .pLsu_bReqValid(req_valid), .pLsu_bReqReady(req_ready), .pLsu_bReqWr(req_wr),
      .pLsu_bReqSize(req_size), .pLsu_bReqSigned(req_signed), .pLsu_bReqAddr(req_addr),
      .pLsu_bReqData(req_data), .pLsu_bRespValid(resp_valid), .pLsu_bRespReady(resp_ready),
      .pLsu_bRespData(resp_data), .pLsu_bRespErr(resp_err),
      .pMem_bRdEn(rd_en), .pMem_bRdAddrB(rd_addr), .pMem_bRdDataB(rd_data),
      .pMem_bWrEn(wr_en), .pMem_bWrAddr(wr_addr), .pMem_bWrData(wr_data),
      .pMem_bWrMask_0(m0), .pMem_bWrMask_1(m1), .pMem_bWrMask_2(m2), .pMem_bWrMask_3(m3)
   );

   always #5 clock = ~clock;

   assign rd_data = mem[rd_addr[11:2]];

   // Byte-lane write port of the memory model.
   always @(posedge clock) begin
      if (wr_en) begin
         if (m0) mem[wr_addr[11:2]][7:0]   <= wr_data[7:0];
         if (m1) mem[wr_addr[11:2]][15:8]  <= wr_data[15:8];
         if (m2) mem[wr_addr[11:2]][23:16] <= wr_data[23:16];
         if (m3) mem[wr_addr[11:2]][31:24] <= wr_data[31:24];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Issue one request and follow it until RespValid (bounded), recording memory activity.
   task automatic txn(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d);
      @(negedge clock);
      check_val("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_wr = wr; req_size = sz; req_signed = sg;
      req_addr = a; req_data = d;
      @(posedge clock);
      #1;
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_data = 32'hFFFF_FFFF;
      lat = 0; seen_rd = 1'b0; seen_wr = 1'b0;
      obs_rd_addr = 32'h0; obs_wr_addr = 32'h0; obs_wr_data = 32'h0; obs_mask = 4'h0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         @(negedge clock);
         if (rd_en) begin
            seen_rd = 1'b1; obs_rd_addr = rd_addr;
         end
         if (wr_en) begin
            seen_wr = 1'b1; obs_wr_addr = wr_addr; obs_wr_data = wr_data;
            obs_mask = {m3, m2, m1, m0};
         end
         if (resp_valid) lat = c;
      end
      if (lat == 0) check_val("resp_timeout", {31'd0, resp_valid}, 32'd1);
   endtask

   task automatic release_resp();
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      resp_ready = 1'b0;
      @(negedge clock);
      check_val("resp_drop", {31'd0, resp_valid}, 32'd0);
   endtask

   task automatic check_resp(input string tag, input int exp_lat, input logic [31:0] exp_data,
                             input logic exp_err);
      check_val({tag, "_lat"}, lat, exp_lat);
      check_val({tag, "_data"}, resp_data, exp_data);
      check_val({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[32'h100 >> 2] = 32'h8899_AABB;
      reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h0; req_data = 32'h0; resp_ready = 1'b0;
      repeat (2) @(negedge clock);
      check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check_val("rst_outs", {resp_valid, resp_err, rd_en, wr_en, m3, m2, m1, m0}, 32'd0);
      check_val("rst_addrs", rd_addr | wr_addr, 32'h0);
      check_val("rst_data", wr_data | resp_data, 32'h0);
      reset = 1'b0;

      // signed byte load from lane 1
      txn(1'b0, 2'b00, 1'b1, 32'h101, 32'h0);
      check_resp("ld_b_s", 2, 32'hFFFF_FFAA, 1'b0);
      check_val("ld_b_s_rdaddr", obs_rd_addr, 32'h100);
      check_val("ld_b_s_seen", {seen_rd, seen_wr}, 32'b10);
      release_resp();

      // half store into the upper half: read-modify-write
      txn(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_1234);
      check_resp("st_h", 3, 32'h0, 1'b0);
      check_val("st_h_seen", {seen_rd, seen_wr}, 32'b11);
      check_val("st_h_rdaddr", obs_rd_addr, 32'h100);
      check_val("st_h_wraddr", obs_wr_addr, 32'h100);
      check_val("st_h_wrdata", obs_wr_data, 32'h1234_AABB);
      check_val("st_h_mask", obs_mask, 32'b1100);
      release_resp();

      txn(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
      check_resp("ld_h_u", 2, 32'h0000_1234, 1'b0);
      release_resp();
      txn(1'b0, 2'b01, 1'b1, 32'h100, 32'h0);
      check_resp("ld_h_s", 2, 32'hFFFF_AABB, 1'b0);
      release_resp();
      txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
      check_resp("ld_b_u", 2, 32'h0000_0012, 1'b0);
      release_resp();

      // word store skips the read
      txn(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF);
      check_resp("st_w", 2, 32'h0, 1'b0);
      check_val("st_w_seen", {seen_rd, seen_wr}, 32'b01);
      check_val("st_w_wraddr", obs_wr_addr, 32'h200);
      check_val("st_w_wrdata", obs_wr_data, 32'hDEAD_BEEF);
      check_val("st_w_mask", obs_mask, 32'b1111);
      release_resp();

      // byte store into lane 1, only low store bits used
      txn(1'b1, 2'b00, 1'b0, 32'h201, 32'hFFFF_FF5A);
      check_resp("st_b", 3, 32'h0, 1'b0);
      check_val("st_b_wrdata", obs_wr_data, 32'hDEAD_5AEF);
      check_val("st_b_mask", obs_mask, 32'b0010);
      release_resp();

      // error cases
      txn(1'b0, 2'b10, 1'b0, 32'h203, 32'h0);
      check_resp("err_w_mis", 1, 32'h0, 1'b1);
      check_val("err_w_mis_seen", {seen_rd, seen_wr}, 32'b00);
      release_resp();
      txn(1'b1, 2'b11, 1'b0, 32'h200, 32'h1111_1111);
      check_resp("err_size", 1, 32'h0, 1'b1);
      check_val("err_size_seen", {seen_rd, seen_wr}, 32'b00);
      release_resp();
      txn(1'b1, 2'b01, 1'b0, 32'h101, 32'h2222_2222);
      check_resp("err_h_mis", 1, 32'h0, 1'b1);
      check_val("err_h_mis_seen", {seen_rd, seen_wr}, 32'b00);
      release_resp();

      // back-pressure: response held, new request ignored
      txn(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
      check_resp("stall", 2, 32'hDEAD_5AEF, 1'b0);
      req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10; req_addr = 32'h100; req_data = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check_val("stall_valid", {31'd0, resp_valid}, 32'd1);
         check_val("stall_data", resp_data, 32'hDEAD_5AEF);
         check_val("stall_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      release_resp();
      check_val("stall_idle", {31'd0, req_ready}, 32'd1);
      check_val("stall_no_wr", mem[32'h100 >> 2], 32'h1234_AABB);
      txn(1'b0, 2'b00, 1'b1, 32'h102, 32'h0);
      check_resp("post_stall", 2, 32'h0000_0034, 1'b0);
      release_resp();

      // reset in the middle of a byte store's write cycle
      @(negedge clock);
      req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h300; req_data = 32'h0000_0077;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(negedge clock);
      check_val("rst_mid_rd", {31'd0, rd_en}, 32'd1);
      @(negedge clock);
      check_val("rst_mid_wr", {31'd0, wr_en}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check_val("rst_async_wr", {wr_en, rd_en, m3, m2, m1, m0}, 32'd0);
      check_val("rst_async_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check_val("rst_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      check_val("rst_ready_after", {31'd0, req_ready}, 32'd1);
      check_val("rst_no_write", mem[32'h300 >> 2], 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/mem_lsu_ctrl.md
MEM_LSU_CTRL -- requirements
Module: mem_lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width; byte lanes = DATA_WIDTH/8 = 4.
REQ-003 SHALL have the following ports, one per line, in this order; the design uses one clock, and reset is asynchronous and active-high:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high
pLsu_bReqValid  in  1  request valid
pLsu_bReqReady  out  1  request accepted when Valid&&Ready
pLsu_bReqWr  in  1  1=store, 0=load
pLsu_bReqSize  in  2  00 byte, 01 half, 10 word, 11 illegal
pLsu_bReqSigned  in  1  load sign-extend enable
pLsu_bReqAddr  in  ADDR_WIDTH  byte address
pLsu_bReqData  in  DATA_WIDTH  store data, right-aligned
pLsu_bRespValid  out  1  response valid
pLsu_bRespReady  in  1  response consumed when Valid&&Ready
pLsu_bRespData  out  DATA_WIDTH  load result; 0 for stores/errors
pLsu_bRespErr  out  1  misaligned or illegal size
pMem_bRdEn  out  1  memory read enable
pMem_bRdAddrB  out  ADDR_WIDTH  word-aligned read address
pMem_bRdDataB  in  DATA_WIDTH  read word, valid by end of RD cycle
pMem_bWrEn  out  1  memory write enable
pMem_bWrAddr  out  ADDR_WIDTH  word-aligned write address
pMem_bWrData  out  DATA_WIDTH  full merged write word
pMem_bWrMask_0..3  out  1 each  byte-lane write strobes

Function
REQ-004 SHALL implement FSM states IDLE, RD, WR, RESP; ReqReady=1 only in IDLE.
REQ-005 On acceptance, SHALL register wr, size, signed, addr, data; request inputs are ignored elsewhere.
REQ-006 Error = size==11, or half with addr[0]=1, or word with addr[1:0]!=0; error SHALL go IDLE->RESP with RespErr=1, RespData=0, no memory enable asserted.
REQ-007 Valid load or byte/half store SHALL go IDLE->RD; valid word store SHALL go IDLE->WR.
REQ-008 RD lasts exactly one cycle: RdEn=1, RdAddrB={addr[ADDR_WIDTH-1:2],2'b00}; on exit SHALL capture pMem_bRdDataB; load->RESP, store->WR.
REQ-009 WR lasts exactly one cycle: WrEn=1, WrAddr aligned as REQ-008, then ->RESP.
REQ-010 Store merge SHALL replace byte lane addr[1:0] (byte) or lanes {addr[1],0..1} (half) of the captured read word with the low store bits; word store SHALL use store data unmodified.
REQ-011 WrMask_n SHALL be 1 exactly for the written lanes during WR, all 0 otherwise.
REQ-012 Load extraction: byte from lane addr[1:0], half from bits [16*addr[1]+15:16*addr[1]], word whole; zero-extend unless Signed=1, then sign-extend from bit 7/15.
REQ-013 RESP SHALL hold RespValid=1 and stable RespData/RespErr until RespReady=1, then go IDLE next cycle; a new request is accepted no earlier than the following cycle.
REQ-014 Memory address/data outputs SHALL be registered and change only when a request is accepted; RdEn/WrEn SHALL be 0 outside RD/WR.
REQ-015 Latency accept->RespValid: error 1 cycle, load 2, word store 2, byte/half store 3.

Reset
REQ-016 Reset SHALL asynchronously force IDLE; ReqReady=1 and all other outputs 0 (addresses, data, masks, RespData, RespErr, RespValid, RdEn, WrEn).
REQ-017 Reset in RD/WR/RESP SHALL drop RdEn/WrEn immediately, abandon the transaction, and produce no response.

Verification
REQ-018 Memory word 0x100=0x8899AABB; load byte signed addr 0x101 -> RD with RdAddrB=0x100, RespData=0xFFFFFFAA, Err=0, 2 cycles.
REQ-019 Same word; store half 0x1234 at 0x102 -> RD then WR: WrAddr=0x100, WrData=0x1234AABB, masks 0,0,1,1; RespData=0.
REQ-020 Word store 0xDEADBEEF at 0x200 -> no RD, WR masks 1,1,1,1, RespValid 2 cycles after accept.
REQ-021 Load word at 0x203, and size=11 at 0x200 -> RespErr=1, RespData=0, RdEn/WrEn never asserted.
REQ-022 RespReady held 0 for 5 cycles -> RespValid/Data stable, ReqReady=0, ReqValid ignored; accepted after release.
REQ-023 Assert reset during WR of a byte store -> WrEn falls asynchronously, no RespValid, ReqReady=1 after reset deasserts.
